sm4_key_fetch: RTL and testbench
================================

SM4_KEY_FETCH -- requirements
Module: sm4_key_fetch

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4, meaning max WAIT cycles per RAM access (legal 1..15).
REQ-002 SHALL have parameter RETRY_MAX, default 1, meaning extra read re-issues after a timeout (legal 0..3; writes never retry).
REQ-003 i_clk  input  1  clock; all logic on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  1  host request strobe, sampled only in IDLE.
REQ-006 i_wr  input  1  1 = write slot, 0 = read slot; captured with i_req.
REQ-007 i_slot  input  7  key slot address; captured with i_req.
REQ-008 i_wdata  input  128  write key; captured with i_req.
REQ-009 o_busy  output  1  high in every state except IDLE.
REQ-010 o_done  output  1  one-cycle completion pulse.
REQ-011 o_err  output  2  status, valid while o_done=1: 00 ok, 01 reserved slot, 10 read timeout, 11 write refused.
REQ-012 o_key  output  128  read key; held until the next accepted request.
REQ-013 o_key_vld  output  1  one-cycle pulse, coincident with o_done on a successful read.
REQ-014 o_ram_ren  output  1  key RAM read strobe.
REQ-015 o_ram_wen  output  1  key RAM write strobe.
REQ-016 o_ram_addr  output  7  key RAM address.
REQ-017 o_ram_wdata  output  128  key RAM write data.
REQ-018 i_ram_key  input  128  key RAM read data.
REQ-019 i_ram_valid  input  1  key RAM read-data-valid pulse.
REQ-020 i_ram_ack  input  1  key RAM write-accepted pulse.

Function
REQ-021 FSM states SHALL be IDLE, CHECK, ISSUE, WAIT, DONE.
REQ-022 IDLE: i_req=1 -> capture i_wr/i_slot/i_wdata, clear o_key to 0, go to CHECK; requests in any other state SHALL be ignored.
REQ-023 CHECK: slot 32, 95 or 127 -> DONE with o_err=01 and no RAM strobe; otherwise -> ISSUE, retry counter = 0.
REQ-024 ISSUE: assert exactly one of o_ram_ren/o_ram_wen for exactly one cycle, with o_ram_addr = slot and o_ram_wdata = wdata (0 on reads); -> WAIT, wait counter = 1.
REQ-025 o_ram_addr/o_ram_wdata SHALL be 0 whenever no strobe is asserted.
REQ-026 WAIT read: i_ram_valid=1 -> latch i_ram_key into o_key, -> DONE with o_err=00.
REQ-027 WAIT write: i_ram_ack=1 -> DONE with o_err=00.
REQ-028 WAIT: response absent and counter == TIMEOUT -> read with retries < RETRY_MAX: increment retry counter, -> ISSUE; read otherwise: o_err=10, o_key=0, -> DONE; write: o_err=11, -> DONE.
REQ-029 WAIT: response absent and counter < TIMEOUT -> increment counter, stay in WAIT.
REQ-030 i_ram_valid/i_ram_ack SHALL be ignored outside WAIT, and the one not matching the operation type SHALL be ignored in WAIT.
REQ-031 DONE: pulse o_done (and o_key_vld if read with err 00) for one cycle, -> IDLE; o_err SHALL hold its value until the next accepted request.
REQ-032 Latency: with a RAM that responds one cycle after the strobe, o_done SHALL be high 4 cycles after the i_req sampling edge (CHECK, ISSUE, WAIT, DONE); reserved slot: 2 cycles.
REQ-033 Back-to-back: i_req held high SHALL start a new request on the first IDLE cycle after DONE.

Reset
REQ-034 i_rst_n low SHALL immediately force: FSM = IDLE; all counters = 0; all outputs = 0, including o_key.
REQ-035 Reset mid-operation SHALL drop any asserted RAM strobe asynchronously and SHALL produce no o_done.

Configuration
REQ-036 Macro KEY_FETCH_UNMASK_EN defined: o_key SHALL latch i_ram_key XOR {64{2'b10}}, and o_ram_wdata SHALL be wdata XOR {64{2'b10}}, so the RAM holds masked keys.
REQ-037 KEY_FETCH_UNMASK_EN undefined: o_key and o_ram_wdata SHALL pass unmodified; no mask logic SHALL be synthesized.

Verification
REQ-038 Write slot 5 with 0x0123...CDEF, RAM acks 1 cycle later -> one o_ram_wen pulse with addr 5; o_done at +4 cycles; o_err=00.
REQ-039 Read slot 5, RAM returns 0x0123...CDEF -> o_key=0x0123...CDEF; o_key_vld and o_done at +4 cycles (macro off).
REQ-040 Read slot 95 -> no RAM strobe; o_done at +2 cycles; o_err=01; o_key=0.
REQ-041 Read slot 7, RAM never responds, defaults -> exactly 2 o_ram_ren pulses; o_err=10; o_key=0; o_done at cycle 1+(1+4)*2+1 = 12.
REQ-042 Write an already-locked slot 5, no ack -> 1 o_ram_wen pulse; o_err=11 after 4 WAIT cycles.
REQ-043 Assert i_rst_n low during WAIT -> all outputs 0 at once; no o_done; next i_req is processed normally.

Source files
------------

// File: rtl/sm4_key_fetch.sv
// SM4 key-slot fetch/store controller: host request -> key RAM read/write with timeout and read retry.
// Optional build macro KEY_FETCH_UNMASK_EN: keys are stored masked in RAM and unmasked on the way in/out.
module sm4_key_fetch #(
  parameter int TIMEOUT   = 4,
  parameter int RETRY_MAX = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req,
  input  logic         i_wr,
  input  logic [6:0]   i_slot,
  input  logic [127:0] i_wdata,
  output logic         o_busy,
  output logic         o_done,
  output logic [1:0]   o_err,
  output logic [127:0] o_key,
  output logic         o_key_vld,
  output logic         o_ram_ren,
  output logic         o_ram_wen,
  output logic [6:0]   o_ram_addr,
  output logic [127:0] o_ram_wdata,
  input  logic [127:0] i_ram_key,
  input  logic         i_ram_valid,
  input  logic         i_ram_ack
);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] TO_CNT = 4'(TIMEOUT);
  localparam logic [1:0] RT_MAX = 2'(RETRY_MAX);

  state_t         r_state, w_state_nxt;
  logic           r_wr;
  logic [6:0]     r_slot;
  logic [127:0]   r_wdata, r_key;
  logic [1:0]     r_err, r_retry;
  logic [3:0]     r_wcnt;

  logic [3:0]     w_wcnt_nxt;
  logic [1:0]     w_retry_nxt, w_err_nxt;
  logic           w_cap, w_err_ld, w_key_ld, w_resp, w_reserved;
  logic [127:0]   w_key_nxt, w_key_in, w_wdata_out;

`ifdef KEY_FETCH_UNMASK_EN
  localparam logic [127:0] KEY_MASK = {64{2'b10}};
  assign w_key_in    = i_ram_key ^ KEY_MASK;
  assign w_wdata_out = r_wdata ^ KEY_MASK;
`else
  assign w_key_in    = i_ram_key;
  assign w_wdata_out = r_wdata;
`endif

  assign w_reserved = (r_slot == 7'd32) || (r_slot == 7'd95) || (r_slot == 7'd127);
  // Only the response matching the operation type counts.
  assign w_resp     = r_wr ? i_ram_ack : i_ram_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_retry_nxt = r_retry;
    w_cap       = 1'b0;
    w_err_ld    = 1'b0;
    w_err_nxt   = r_err;
    w_key_ld    = 1'b0;
    w_key_nxt   = r_key;
    case (r_state)
      S_IDLE: if (i_req) begin
        w_cap       = 1'b1;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_reserved) begin
          w_err_ld    = 1'b1;
          w_err_nxt   = 2'b01;
          w_state_nxt = S_DONE;
        end else begin
          w_retry_nxt = '0;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_wcnt_nxt  = 4'd1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_resp) begin
          w_err_ld    = 1'b1;
          w_err_nxt   = 2'b00;
          w_key_ld    = !r_wr;
          w_key_nxt   = w_key_in;
          w_state_nxt = S_DONE;
        end else if (r_wcnt == TO_CNT) begin
          if (!r_wr && (r_retry < RT_MAX)) begin
            w_retry_nxt = r_retry + 2'd1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_err_ld    = 1'b1;
            w_err_nxt   = r_wr ? 2'b11 : 2'b10;
            w_key_ld    = !r_wr;
            w_key_nxt   = '0;
            w_state_nxt = S_DONE;
          end
        end else begin
          w_wcnt_nxt = r_wcnt + 4'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, status and key holding registers; cleared only by a new accepted request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= 1'b0;
      r_slot  <= '0;
      r_wdata <= '0;
      r_key   <= '0;
      r_err   <= '0;
    end else if (w_cap) begin
      r_wr    <= i_wr;
      r_slot  <= i_slot;
      r_wdata <= i_wdata;
      r_key   <= '0;
      r_err   <= '0;
    end else begin
      if (w_err_ld) r_err <= w_err_nxt;
      if (w_key_ld) r_key <= w_key_nxt;
    end
  end

  // Outputs decode directly from the state register so reset removes them immediately.
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_err       = r_err;
  assign o_key       = r_key;
  assign o_key_vld   = (r_state == S_DONE) && !r_wr && (r_err == 2'b00);
  assign o_ram_ren   = (r_state == S_ISSUE) && !r_wr;
  assign o_ram_wen   = (r_state == S_ISSUE) && r_wr;
  assign o_ram_addr  = (r_state == S_ISSUE) ? r_slot : 7'd0;
  assign o_ram_wdata = (r_state == S_ISSUE && r_wr) ? w_wdata_out : 128'd0;
endmodule

// File: tb/tb_sm4_key_fetch.sv
// Directed bench for sm4_key_fetch: write/read, reserved slot, timeouts, reset mid-op, back-to-back.
module tb_sm4_key_fetch;
  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_req, i_wr;
  logic [6:0]   i_slot;
  logic [127:0] i_wdata, i_ram_key;
  logic         i_ram_valid, i_ram_ack;
  logic         o_busy, o_done, o_key_vld, o_ram_ren, o_ram_wen;
  logic [1:0]   o_err;
  logic [127:0] o_key, o_ram_wdata;
  logic [6:0]   o_ram_addr;

  sm4_key_fetch dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_wr(i_wr), .i_slot(i_slot),
    .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_key(o_key),
    .o_key_vld(o_key_vld), .o_ram_ren(o_ram_ren), .o_ram_wen(o_ram_wen),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_key(i_ram_key),
    .i_ram_valid(i_ram_valid), .i_ram_ack(i_ram_ack)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [127:0] KEY = 128'h0123456789ABCDEF0123456789ABCDEF;

  int errors = 0, checks = 0;
  int done_cyc, ren_n, wen_n, bad;
  logic [6:0]   s_addr;
  logic [127:0] s_wdata, d_key;
  logic [1:0]   d_err;
  logic         d_kv, cur_wr, pend;
  logic [7:0]   dmask;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic wr, input logic [6:0] slot, input logic [127:0] wd);
    @(negedge i_clk);
    i_req = 1'b1; i_wr = wr; i_slot = slot; i_wdata = wd; cur_wr = wr;
    @(posedge i_clk); #1;
    i_req = 1'b0;
  endtask

  // Cycle c=1 is the cycle right after the request sampling edge; RAM answers one cycle after a strobe.
  task automatic run(input logic respond, input logic [127:0] rkey);
    done_cyc = 0; ren_n = 0; wen_n = 0; bad = 0; s_addr = '0; s_wdata = '0; pend = 1'b0;
    d_err = 'x; d_key = 'x; d_kv = 1'bx;
    for (int c = 1; c <= 30; c++) begin
      @(negedge i_clk);
      if (o_ram_ren || o_ram_wen) begin
        ren_n += int'(o_ram_ren); wen_n += int'(o_ram_wen);
        s_addr = o_ram_addr; s_wdata = o_ram_wdata; pend = respond;
      end else if (o_ram_addr != 0 || o_ram_wdata != 0) bad++;
      if (o_done) begin
        done_cyc = c; d_err = o_err; d_key = o_key; d_kv = o_key_vld;
        break;
      end
      @(posedge i_clk); #1;
      i_ram_valid = pend && !cur_wr;
      i_ram_ack   = pend && cur_wr;
      i_ram_key   = pend ? rkey : 128'd0;
      pend = 1'b0;
    end
    i_ram_valid = 1'b0; i_ram_ack = 1'b0; i_ram_key = '0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_req = 1'b0; i_wr = 1'b0; i_slot = '0; i_wdata = '0;
    i_ram_key = '0; i_ram_valid = 1'b0; i_ram_ack = 1'b0; cur_wr = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_key", o_key, 0);
    chk("rst_strobes", {o_ram_ren, o_ram_wen, o_key_vld}, 0);
    chk("rst_addr_wdata", {o_ram_addr, o_ram_wdata}, 0);
    @(negedge i_clk); i_rst_n = 1'b1;

    // write slot 5, RAM acks
    start(1'b1, 7'd5, KEY); run(1'b1, '0);
    chk("wr_done_cyc", done_cyc, 4);
    chk("wr_wen_n", wen_n, 1);
    chk("wr_ren_n", ren_n, 0);
    chk("wr_addr", s_addr, 5);
    chk("wr_wdata", s_wdata, KEY);
    chk("wr_err", d_err, 2'b00);
    chk("wr_kv", d_kv, 0);
    chk("wr_idle_bus", bad, 0);

    // read slot 5, RAM returns KEY
    start(1'b0, 7'd5, 128'hFFFF); run(1'b1, KEY);
    chk("rd_done_cyc", done_cyc, 4);
    chk("rd_ren_n", ren_n, 1);
    chk("rd_wdata_zero", s_wdata, 0);
    chk("rd_key", d_key, KEY);
    chk("rd_kv", d_kv, 1);
    chk("rd_err", d_err, 2'b00);
    @(negedge i_clk);
    chk("rd_key_held", o_key, KEY);
    chk("rd_kv_pulse", {o_key_vld, o_done, o_busy}, 0);

    // reserved slots
    start(1'b0, 7'd95, '0); run(1'b1, KEY);
    chk("rsv95_done_cyc", done_cyc, 2);
    chk("rsv95_strobes", ren_n + wen_n, 0);
    chk("rsv95_err", d_err, 2'b01);
    chk("rsv95_key", d_key, 0);
    chk("rsv95_kv", d_kv, 0);
    start(1'b1, 7'd32, KEY); run(1'b1, '0);
    chk("rsv32_done_cyc", done_cyc, 2);
    chk("rsv32_err_strb", {d_err, 4'(ren_n + wen_n)}, {2'b01, 4'd0});

    // read timeout with one retry
    start(1'b0, 7'd7, '0); run(1'b0, '0);
    chk("rto_done_cyc", done_cyc, 12);
    chk("rto_ren_n", ren_n, 2);
    chk("rto_addr", s_addr, 7);
    chk("rto_err", d_err, 2'b10);
    chk("rto_key", d_key, 0);
    chk("rto_idle_bus", bad, 0);

    // write refused (no ack), never retried
    start(1'b1, 7'd5, KEY); run(1'b0, '0);
    chk("wto_done_cyc", done_cyc, 7);
    chk("wto_wen_n", wen_n, 1);
    chk("wto_err", d_err, 2'b11);

    // reset while the read strobe is up
    start(1'b0, 7'd9, '0);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("mid_ren_before", o_ram_ren, 1);
    i_rst_n = 1'b0; #1;
    chk("mid_ren_after", o_ram_ren, 0);
    chk("mid_outs", {o_busy, o_done, o_err, o_key_vld, o_ram_wen, o_ram_addr}, 0);
    chk("mid_key", o_key, 0);
    begin
      int dn = 0;
      repeat (3) begin @(negedge i_clk); dn += int'(o_done); end
      chk("mid_no_done", dn, 0);
    end
    i_rst_n = 1'b1;
    start(1'b0, 7'd5, '0); run(1'b1, KEY);
    chk("post_rst_done_cyc", done_cyc, 4);
    chk("post_rst_key", d_key, KEY);

    // back-to-back: i_req held across two reserved-slot requests
    @(negedge i_clk);
    i_req = 1'b1; i_wr = 1'b0; i_slot = 7'd127;
    dmask = '0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge i_clk); @(negedge i_clk);
      if (o_done) dmask[c] = 1'b1;
    end
    i_req = 1'b0;
    chk("b2b_done_mask", dmask, 8'b0010_0100);
    repeat (4) @(negedge i_clk);
    chk("b2b_idle", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
